// File: rtl/det3x3_seq.sv
// det3x3_seq: handshaked 3x3 / 2x2 integer determinant engine.
// Cofactor expansion along row 0 using one shared multiplier; the six 2x2
// minor products are computed first, then combined with the row-0 elements.
module det3x3_seq #(
    parameter int W      = 5,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode2,
    input  logic [9*W-1:0]        matrix_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [3*W+2:0] determinant
);

    localparam int DW = 3*W + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r, next_state_s;

    logic [9*W-1:0]        mat_r;
    logic                  mode2_r;
    logic [3:0]            k_r;
    logic signed [DW-1:0]  p0_r, p1_r, p2_r, p3_r, p4_r, p5_r;
    logic signed [DW-1:0]  acc_r, acc_next_s;
    logic signed [DW-1:0]  determinant_r;
    logic                  in_ready_r, out_valid_r;
    logic signed [DW-1:0]  e_s [0:8];
    logic signed [DW-1:0]  mul_a_s, mul_b_s, prod_s;
    logic                  last_s, accept_s;

    // Zero- or sign-extend one element to the full determinant width.
    function automatic logic signed [DW-1:0] ext(input logic [W-1:0] e);
        if (SIGNED != 0) begin
            ext = {{(DW-W){e[W-1]}}, e};
        end else begin
            ext = {{(DW-W){1'b0}}, e};
        end
    endfunction

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign determinant = determinant_r;
    assign accept_s    = (state_r == IDLE) && in_valid && in_ready_r;
    assign last_s      = mode2_r ? (k_r == 4'd1) : (k_r == 4'd8);
    assign prod_s      = mul_a_s * mul_b_s;

    // Unpack the latched matrix into extended elements, row-major index 3r+c.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            e_s[i] = ext(mat_r[(8-i)*W +: W]);
        end
    end

    // Select the multiplier operands for the current schedule step.
    always_comb begin
        mul_a_s = {DW{1'b0}};
        mul_b_s = {DW{1'b0}};
        if (mode2_r) begin
            case (k_r)
                4'd0:    begin mul_a_s = e_s[0]; mul_b_s = e_s[4]; end
                4'd1:    begin mul_a_s = e_s[3]; mul_b_s = e_s[1]; end
                default: begin mul_a_s = {DW{1'b0}}; mul_b_s = {DW{1'b0}}; end
            endcase
        end else begin
            case (k_r)
                4'd0:    begin mul_a_s = e_s[4]; mul_b_s = e_s[8]; end
                4'd1:    begin mul_a_s = e_s[7]; mul_b_s = e_s[5]; end
                4'd2:    begin mul_a_s = e_s[3]; mul_b_s = e_s[8]; end
                4'd3:    begin mul_a_s = e_s[6]; mul_b_s = e_s[5]; end
                4'd4:    begin mul_a_s = e_s[3]; mul_b_s = e_s[7]; end
                4'd5:    begin mul_a_s = e_s[6]; mul_b_s = e_s[4]; end
                4'd6:    begin mul_a_s = e_s[0]; mul_b_s = p0_r - p1_r; end
                4'd7:    begin mul_a_s = e_s[1]; mul_b_s = p2_r - p3_r; end
                4'd8:    begin mul_a_s = e_s[2]; mul_b_s = p4_r - p5_r; end
                default: begin mul_a_s = {DW{1'b0}}; mul_b_s = {DW{1'b0}}; end
            endcase
        end
    end

    // Accumulator update: signed cofactor terms (3x3) or the final 2x2 difference.
    always_comb begin
        acc_next_s = acc_r;
        if (mode2_r) begin
            if (k_r == 4'd1) begin
                acc_next_s = p0_r - prod_s;
            end else begin
                acc_next_s = acc_r;
            end
        end else begin
            case (k_r)
                4'd6:    acc_next_s = acc_r + prod_s;
                4'd7:    acc_next_s = acc_r - prod_s;
                4'd8:    acc_next_s = acc_r + prod_s;
                default: acc_next_s = acc_r;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; DONE always returns to IDLE, never straight to MUL.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_state_s = MUL;
                else          next_state_s = IDLE;
            end
            MUL: begin
                if (last_s) next_state_s = DONE;
                else        next_state_s = MUL;
            end
            DONE: begin
                if (out_ready) next_state_s = IDLE;
                else           next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mat_r         <= {(9*W){1'b0}};
            mode2_r       <= 1'b0;
            k_r           <= 4'd0;
            p0_r          <= {DW{1'b0}};
            p1_r          <= {DW{1'b0}};
            p2_r          <= {DW{1'b0}};
            p3_r          <= {DW{1'b0}};
            p4_r          <= {DW{1'b0}};
            p5_r          <= {DW{1'b0}};
            acc_r         <= {DW{1'b0}};
            determinant_r <= {DW{1'b0}};
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
        end else begin
            in_ready_r  <= (next_state_s == IDLE);
            out_valid_r <= (next_state_s == DONE);
            if (accept_s) begin
                mat_r   <= matrix_in;
                mode2_r <= in_mode2;
                k_r     <= 4'd0;
                acc_r   <= {DW{1'b0}};
            end else if (state_r == MUL) begin
                k_r   <= k_r + 4'd1;
                acc_r <= acc_next_s;
                if (last_s) begin
                    determinant_r <= acc_next_s;
                end
                if (mode2_r) begin
                    if (k_r == 4'd0) p0_r <= prod_s;
                end else begin
                    case (k_r)
                        4'd0:    p0_r <= prod_s;
                        4'd1:    p1_r <= prod_s;
                        4'd2:    p2_r <= prod_s;
                        4'd3:    p3_r <= prod_s;
                        4'd4:    p4_r <= prod_s;
                        4'd5:    p5_r <= prod_s;
                        default: p0_r <= p0_r;
                    endcase
                end
            end
        end
    end

endmodule
